// File: rtl/enigma_pkg.sv
// Shared types, rotor/reflector tables and modulo-26 helpers for the Enigma-I decoder.
package enigma_pkg;

  localparam int NUM_TYPES = 5;
  localparam int FIELD_W   = 5;
  localparam int TYPE_W    = 3;

  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_READY = 2'd1,
    ST_XLATE = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Turnover positions for rotors I..V (Q, E, V, J, Z).
  localparam int NOTCH [5] = '{16, 4, 21, 9, 25};

  localparam int REFLECTOR_B [26] = '{
    24, 17, 20, 7, 16, 18, 11, 3, 15, 23, 13, 6, 14,
    10, 12, 8, 4, 1, 5, 25, 2, 22, 21, 9, 0, 19};

  localparam int WIRING [5][26] = '{
    '{4, 10, 12, 5, 11, 6, 3, 16, 21, 25, 13, 19, 14,
      22, 24, 7, 23, 20, 18, 15, 0, 8, 1, 17, 2, 9},
    '{0, 9, 3, 10, 18, 8, 17, 20, 23, 1, 11, 7, 22,
      19, 12, 2, 16, 6, 25, 13, 15, 24, 5, 21, 14, 4},
    '{1, 3, 5, 7, 9, 11, 2, 15, 17, 19, 23, 21, 25,
      13, 24, 4, 8, 22, 6, 0, 10, 12, 20, 18, 16, 14},
    '{4, 18, 14, 21, 15, 25, 9, 0, 24, 16, 20, 8, 17,
      7, 23, 11, 13, 5, 19, 6, 10, 3, 2, 12, 22, 1},
    '{21, 25, 1, 17, 6, 8, 19, 24, 20, 15, 18, 3, 13,
      7, 11, 23, 0, 22, 12, 9, 16, 14, 5, 4, 2, 10}};

  // Both operands are 0..25, so one correction brings the result back into range.
  function automatic logic [4:0] mod26_add(input logic [4:0] a, input logic [4:0] b);
    logic signed [6:0] s;
    s = $signed({2'b00, a}) + $signed({2'b00, b});
    if (s >= 7'sd26) s = s - 7'sd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] mod26_sub(input logic [4:0] a, input logic [4:0] b);
    logic signed [6:0] s;
    s = $signed({2'b00, a}) - $signed({2'b00, b});
    if (s < 7'sd0) s = s + 7'sd26;
    return s[4:0];
  endfunction

endpackage

// File: rtl/enigma_decoder_rotor_stage.sv
// One rotor pass: ring/position offset, wiring lookup (forward or inverse), offset removal.
module rotor_stage
  import enigma_pkg::*;
#(
  parameter bit REVERSE = 1'b0
) (
  input  logic [2:0] rotor_type,
  input  logic [4:0] ring,
  input  logic [4:0] pos,
  input  logic [4:0] x,
  output logic [4:0] y
);

  logic [2:0] sel;
  logic [4:0] entry;
  logic [4:0] wired;

  always_comb begin
    sel   = (rotor_type < 3'd5) ? rotor_type : 3'd0;
    entry = mod26_add(mod26_sub(x, ring), pos);
    wired = 5'd0;
    if (!REVERSE) begin
      wired = 5'(WIRING[sel][entry]);
    end else begin
      // Inverse wiring found by search so only the forward table has to be maintained.
      for (int i = 0; i < 26; i++) begin
        if (WIRING[sel][i] == int'(entry)) wired = 5'(i);
      end
    end
    y = mod26_sub(mod26_add(wired, ring), pos);
  end

endmodule

// File: rtl/enigma_decoder_rotor_stepper.sv
// Keypress stepping with the mid-rotor double step; all decisions use pre-step positions.
module rotor_stepper
  import enigma_pkg::*;
(
  input  logic [14:0] pos,
  input  logic [8:0]  types,
  output logic [14:0] next_pos
);

  logic [4:0] pos_r, pos_m, pos_l;
  logic       at_notch_r, at_notch_m;

  always_comb begin
    pos_r = pos[4:0];
    pos_m = pos[9:5];
    pos_l = pos[14:10];
    at_notch_r = (int'(pos_r) == NOTCH[(types[2:0] < 3'd5) ? types[2:0] : 3'd0]);
    at_notch_m = (int'(pos_m) == NOTCH[(types[5:3] < 3'd5) ? types[5:3] : 3'd0]);
    next_pos[4:0]   = mod26_add(pos_r, 5'd1);
    next_pos[9:5]   = (at_notch_r || at_notch_m) ? mod26_add(pos_m, 5'd1) : pos_m;
    next_pos[14:10] = at_notch_m ? mod26_add(pos_l, 5'd1) : pos_l;
  end

endmodule

// File: rtl/enigma_decoder.sv
// Streaming Enigma-I decipher engine: configure rotors, then one letter in, one letter out.
//   state  | meaning
//   UNCFG  | no legal configuration loaded, input blocked
//   READY  | waiting for a ciphertext letter
//   XLATE  | letter latched, rotors stepped, result being registered
//   OUT    | plaintext held until downstream accepts
module enigma_decoder #(
  parameter int NUM_TYPES = enigma_pkg::NUM_TYPES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_load,
  input  logic [8:0]  cfg_type,
  input  logic [14:0] cfg_ring,
  input  logic [14:0] cfg_start,
  output logic        cfg_err,
  input  logic        in_valid,
  input  logic [4:0]  in_char,
  output logic        in_ready,
  output logic        out_valid,
  output logic [4:0]  out_char,
  input  logic        out_ready,
  output logic [14:0] pos
);
  import enigma_pkg::*;

  state_t      state;
  logic [8:0]  types_q;
  logic [14:0] ring_q;
  logic [4:0]  char_q;
  logic [14:0] next_pos;
  logic        cfg_ok;
  logic        char_is_letter;
  logic [4:0]  s_in, s_fr, s_fm, s_fl, s_ref, s_rl, s_rm, s_rr;

  always_comb begin
    cfg_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (int'(cfg_type[i*3 +: 3]) >= NUM_TYPES) cfg_ok = 1'b0;
      if (cfg_ring[i*5 +: 5] > 5'd25)             cfg_ok = 1'b0;
      if (cfg_start[i*5 +: 5] > 5'd25)            cfg_ok = 1'b0;
    end
  end

  rotor_stepper u_stepper (
    .pos      (pos),
    .types    (types_q),
    .next_pos (next_pos)
  );

  // Non-letters bypass the rotors; feed a harmless value so the lookups stay in range.
  assign char_is_letter = (char_q < 5'd26);
  assign s_in           = char_is_letter ? char_q : 5'd0;

  rotor_stage #(.REVERSE(1'b0)) u_fwd_r (
    .rotor_type(types_q[2:0]), .ring(ring_q[4:0]), .pos(pos[4:0]), .x(s_in), .y(s_fr));
  rotor_stage #(.REVERSE(1'b0)) u_fwd_m (
    .rotor_type(types_q[5:3]), .ring(ring_q[9:5]), .pos(pos[9:5]), .x(s_fr), .y(s_fm));
  rotor_stage #(.REVERSE(1'b0)) u_fwd_l (
    .rotor_type(types_q[8:6]), .ring(ring_q[14:10]), .pos(pos[14:10]), .x(s_fm), .y(s_fl));

  assign s_ref = 5'(REFLECTOR_B[s_fl]);

  rotor_stage #(.REVERSE(1'b1)) u_rev_l (
    .rotor_type(types_q[8:6]), .ring(ring_q[14:10]), .pos(pos[14:10]), .x(s_ref), .y(s_rl));
  rotor_stage #(.REVERSE(1'b1)) u_rev_m (
    .rotor_type(types_q[5:3]), .ring(ring_q[9:5]), .pos(pos[9:5]), .x(s_rl), .y(s_rm));
  rotor_stage #(.REVERSE(1'b1)) u_rev_r (
    .rotor_type(types_q[2:0]), .ring(ring_q[4:0]), .pos(pos[4:0]), .x(s_rm), .y(s_rr));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_UNCFG;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_char  <= 5'd0;
      cfg_err   <= 1'b0;
      pos       <= 15'd0;
      types_q   <= 9'd0;
      ring_q    <= 15'd0;
      char_q    <= 5'd0;
    end else if (cfg_load) begin
      // A new configuration always discards whatever letter is in flight.
      out_valid <= 1'b0;
      if (cfg_ok) begin
        pos      <= cfg_start;
        types_q  <= cfg_type;
        ring_q   <= cfg_ring;
        cfg_err  <= 1'b0;
        in_ready <= 1'b1;
        state    <= ST_READY;
      end else begin
        cfg_err  <= 1'b1;
        in_ready <= 1'b0;
        state    <= ST_UNCFG;
      end
    end else begin
      case (state)
        ST_UNCFG: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
        ST_READY: begin
          if (in_valid) begin
            char_q   <= in_char;
            in_ready <= 1'b0;
            state    <= ST_XLATE;
            if (in_char < 5'd26) pos <= next_pos;
          end
        end
        ST_XLATE: begin
          out_char  <= char_is_letter ? s_rr : char_q;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_READY;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          state     <= ST_UNCFG;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_decoder.sv
// Bench for enigma_decoder: directed scenarios plus random traffic against a letter-level model.
module tb_enigma_decoder;

  logic        clk = 1'b0;
  logic        reset, cfg_load;
  logic [8:0]  cfg_type;
  logic [14:0] cfg_ring, cfg_start;
  logic        cfg_err;
  logic        in_valid;
  logic [4:0]  in_char;
  logic        in_ready, out_valid;
  logic [4:0]  out_char;
  logic        out_ready;
  logic [14:0] pos;

  int checks = 0;
  int failures = 0;

  enigma_decoder dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_type(cfg_type),
    .cfg_ring(cfg_ring), .cfg_start(cfg_start), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready), .pos(pos));

  always #5 clk = ~clk;

  string wir [5] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                     "BDFHJLCPRTXVZNYEIWGAKMUSQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                     "VZBRGITYUPSDNHLXAWMJQOFECK"};
  string refl    = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  string notches = "QEVJZ";

  // Model state, index 0 = right rotor, 1 = mid, 2 = left.
  int m_type [3];
  int m_ring [3];
  int m_pos  [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m26(input int v);
    return ((v % 26) + 26) % 26;
  endfunction

  function automatic int pk(input int l, input int m, input int r);
    return l * 1024 + m * 32 + r;
  endfunction

  function automatic int model_pos();
    return pk(m_pos[2], m_pos[1], m_pos[0]);
  endfunction

  function automatic int letter(input string s, input int i);
    return int'(s[i]) - 65;
  endfunction

  function automatic int enc(input int c, input int r, input bit rev);
    int e, w;
    e = m26(c - m_ring[r] + m_pos[r]);
    w = 0;
    if (!rev) w = letter(wir[m_type[r]], e);
    else for (int i = 0; i < 26; i++) if (letter(wir[m_type[r]], i) == e) w = i;
    return m26(w + m_ring[r] - m_pos[r]);
  endfunction

  function automatic void model_step();
    bit at_r, at_m;
    at_r = (m_pos[0] == letter(notches, m_type[0]));
    at_m = (m_pos[1] == letter(notches, m_type[1]));
    m_pos[0] = m26(m_pos[0] + 1);
    if (at_r || at_m) m_pos[1] = m26(m_pos[1] + 1);
    if (at_m) m_pos[2] = m26(m_pos[2] + 1);
  endfunction

  function automatic int decipher(input int c);
    int v;
    v = enc(c, 0, 0);
    v = enc(v, 1, 0);
    v = enc(v, 2, 0);
    v = letter(refl, v);
    v = enc(v, 2, 1);
    v = enc(v, 1, 1);
    return enc(v, 0, 1);
  endfunction

  task automatic drive_cfg(input int tl, input int tm, input int tr, input int rl, input int rm,
                           input int rr, input int sl, input int sm, input int sr);
    cfg_type  = {3'(tl), 3'(tm), 3'(tr)};
    cfg_ring  = {5'(rl), 5'(rm), 5'(rr)};
    cfg_start = {5'(sl), 5'(sm), 5'(sr)};
    cfg_load  = 1'b1;
  endtask

  task automatic do_cfg(input int tl, input int tm, input int tr, input int rl, input int rm,
                        input int rr, input int sl, input int sm, input int sr);
    drive_cfg(tl, tm, tr, rl, rm, rr, sl, sm, sr);
    m_type = '{tr, tm, tl};
    m_ring = '{rr, rm, rl};
    m_pos  = '{sr, sm, sl};
    @(negedge clk);
    cfg_load = 1'b0;
    chk("cfg_err_legal", cfg_err, 0);
    chk("cfg_in_ready", in_ready, 1);
    chk("cfg_pos", pos, model_pos());
  endtask

  // Call at a negedge with the engine in READY; returns at a negedge back in READY.
  task automatic send(input int c, input int stall, output int got);
    int exp, n;
    logic [4:0] held;
    if (c < 26) begin
      model_step();
      exp = decipher(c);
    end else begin
      exp = c;
    end
    got = -1;
    chk("send_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_char   = 5'(c);
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", out_valid, 1);
    if (out_valid) begin
      got  = int'(out_char);
      held = out_char;
      chk("out_char", out_char, exp);
      chk("pos_after_step", pos, model_pos());
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_char", out_char, held);
        chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_valid", out_valid, 0);
      chk("release_in_ready", in_ready, 1);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int got, c, n;
    int t[3], r[3], s[3];
    int ciph[5] = '{1, 3, 25, 6, 14};

    reset = 1'b1; cfg_load = 1'b0; cfg_type = '0; cfg_ring = '0; cfg_start = '0;
    in_valid = 1'b0; in_char = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_pos", pos, 0);
    reset = 1'b0;
    @(negedge clk);

    // Rotors I-II-III, rings AAA, start AAA: BDZGO deciphers to AAAAA.
    do_cfg(0, 1, 2, 0, 0, 0, 0, 0, 0);
    foreach (ciph[i]) begin
      send(ciph[i], 0, got);
      chk("t1_plain_a", got, 0);
    end
    chk("t1_pos_end", pos, pk(0, 0, 5));

    // Start ADU: double step of the middle rotor.
    do_cfg(0, 1, 2, 0, 0, 0, 0, 3, 20);
    send(0, 0, got); chk("t2_pos_adv", pos, pk(0, 3, 21));
    send(0, 0, got); chk("t2_pos_aew", pos, pk(0, 4, 22));
    send(0, 0, got); chk("t2_pos_bfx", pos, pk(1, 5, 23));

    // Right rotor wraps 25 -> 0 without a notch.
    do_cfg(0, 1, 2, 3, 7, 11, 0, 0, 25);
    send(7, 0, got);
    chk("t3_wrap", pos, pk(0, 0, 0));

    // Downstream backpressure for 10 cycles.
    send($urandom_range(0, 25), 10, got);

    // Illegal configurations leave position and stored config alone.
    drive_cfg(0, 1, 7, 0, 0, 0, 4, 4, 4);
    @(negedge clk);
    cfg_load = 1'b0;
    chk("t5_err_type", cfg_err, 1);
    chk("t5_uncfg_ready", in_ready, 0);
    chk("t5_pos_kept", pos, model_pos());
    in_valid = 1'b1; in_char = 5'd3;
    repeat (3) @(negedge clk);
    chk("t5_no_accept", out_valid, 0);
    chk("t5_no_step", pos, model_pos());
    in_valid = 1'b0;
    drive_cfg(0, 1, 2, 26, 0, 0, 0, 0, 0);
    @(negedge clk);
    cfg_load = 1'b0;
    chk("t5_err_ring", cfg_err, 1);
    // The stored config is unchanged, so after a legal reload the model still matches.
    do_cfg(4, 3, 2, 5, 9, 13, 1, 2, 3);
    send(11, 0, got);

    // cfg_load while a letter waits in OUT: letter discarded.
    out_ready = 1'b0;
    in_valid = 1'b1; in_char = 5'd9;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 6) begin @(negedge clk); n++; end
    chk("t5_out_seen", out_valid, 1);
    do_cfg(1, 0, 3, 2, 2, 2, 10, 20, 5);
    chk("t5_dropped", out_valid, 0);
    out_ready = 1'b1;

    // cfg_load on the handshake cycle: letter not accepted.
    in_valid = 1'b1; in_char = 5'd4;
    do_cfg(1, 0, 3, 2, 2, 2, 10, 20, 5);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_collide_valid", out_valid, 0);
    chk("t5_collide_pos", pos, model_pos());
    send(4, 1, got);

    // Random traffic against the model.
    for (int round = 0; round < 4; round++) begin
      foreach (t[i]) begin
        t[i] = $urandom_range(0, 4);
        r[i] = $urandom_range(0, 25);
        s[i] = $urandom_range(0, 25);
      end
      do_cfg(t[2], t[1], t[0], r[2], r[1], r[0], s[2], s[1], s[0]);
      for (int k = 0; k < 20; k++) begin
        c = ($urandom_range(0, 7) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
        send(c, $urandom_range(0, 3), got);
      end
    end

    // Out-of-range input passes through without stepping.
    send(28, 0, got);
    chk("t6_passthru", got, 28);

    // Reset while a letter is being translated.
    in_valid = 1'b1; in_char = 5'd5;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_char", out_char, 0);
    chk("t6_rst_pos", pos, 0);
    chk("t6_rst_err", cfg_err, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_post_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
